// File: rtl/lm32_logic_arbiter_pkg.sv
// Shared types and constants for the lm32 logic-unit arbiter.
// Word/op widths, buffer state encoding, op codes, request bundle.
package lm32_logic_arbiter_pkg;

  localparam int LM32_WORD_WIDTH     = 32;
  localparam int LM32_LOGIC_OP_WIDTH = 4;

  typedef logic [LM32_WORD_WIDTH-1:0]     lm32_word_t;
  typedef logic [LM32_LOGIC_OP_WIDTH-1:0] lm32_logic_op_t;

  // Result buffer state.
  typedef enum logic {
    LM32_LOGIC_ARB_EMPTY = 1'b0,
    LM32_LOGIC_ARB_FULL  = 1'b1
  } lm32_logic_arb_state_e;

  // Truth-table op codes: result bit = op[{b,a}].
  localparam lm32_logic_op_t LM32_LOGIC_OP_AND = 4'b1000;
  localparam lm32_logic_op_t LM32_LOGIC_OP_OR  = 4'b1110;
  localparam lm32_logic_op_t LM32_LOGIC_OP_XOR = 4'b0110;
  localparam lm32_logic_op_t LM32_LOGIC_OP_NOR = 4'b0001;

  typedef struct packed {
    lm32_logic_op_t op;
    lm32_word_t     a;
    lm32_word_t     b;
  } lm32_logic_req_t;

endpackage

// File: rtl/lm32_logic_op.sv
// Bitwise truth-table logic unit: result[i] = op[{b[i],a[i]}].
// Ports: op (4b), a/b operands (32b), result (32b); purely combinational.
module lm32_logic_op
  import lm32_logic_arbiter_pkg::*;
(
  input  logic [LM32_LOGIC_OP_WIDTH-1:0] op,
  input  logic [LM32_WORD_WIDTH-1:0]     a,
  input  logic [LM32_WORD_WIDTH-1:0]     b,
  output logic [LM32_WORD_WIDTH-1:0]     result
);

  always_comb begin
    result = '0;
    for (int i = 0; i < LM32_WORD_WIDTH; i++) begin
      result[i] = op[{b[i], a[i]}];
    end
  end

endmodule

// File: rtl/lm32_logic_arbiter.sv
// Two-port valid/ready arbiter sharing one lm32_logic_op unit.
// Ports: clk_i, rst_i, req0/req1 {valid,ready,op,a,b}, rsp {valid,ready,result,id}, busy_o.
module lm32_logic_arbiter
  import lm32_logic_arbiter_pkg::*;
#(
  parameter int FIXED_PRIORITY = 0
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           req0_valid_i,
  output logic                           req0_ready_o,
  input  logic [LM32_LOGIC_OP_WIDTH-1:0] req0_op_i,
  input  logic [LM32_WORD_WIDTH-1:0]     req0_a_i,
  input  logic [LM32_WORD_WIDTH-1:0]     req0_b_i,
  input  logic                           req1_valid_i,
  output logic                           req1_ready_o,
  input  logic [LM32_LOGIC_OP_WIDTH-1:0] req1_op_i,
  input  logic [LM32_WORD_WIDTH-1:0]     req1_a_i,
  input  logic [LM32_WORD_WIDTH-1:0]     req1_b_i,
  output logic                           rsp_valid_o,
  input  logic                           rsp_ready_i,
  output logic [LM32_WORD_WIDTH-1:0]     rsp_result_o,
  output logic                           rsp_id_o,
  output logic                           busy_o
);

  lm32_logic_arb_state_e state_q;
  logic                  last_grant_q;
  lm32_word_t            result_q;
  logic                  id_q;

  lm32_logic_req_t req0, req1, sel;
  lm32_word_t      op_result;
  logic            grant;
  logic            free;
  logic            fire;

  assign req0 = '{op: req0_op_i, a: req0_a_i, b: req0_b_i};
  assign req1 = '{op: req1_op_i, a: req1_a_i, b: req1_b_i};

  // On a tie, round-robin favours the port not granted last.
  always_comb begin
    grant = 1'b0;
    if (req0_valid_i && req1_valid_i) begin
      grant = (FIXED_PRIORITY != 0) ? 1'b0 : ~last_grant_q;
    end else if (req1_valid_i) begin
      grant = 1'b1;
    end
  end

  // A FULL buffer can take a new result only while it is being popped.
  assign free = (state_q == LM32_LOGIC_ARB_EMPTY) | rsp_ready_i;

  assign req0_ready_o = ~rst_i & free & req0_valid_i & ~grant;
  assign req1_ready_o = ~rst_i & free & req1_valid_i & grant;
  assign fire         = req0_ready_o | req1_ready_o;

  assign sel = grant ? req1 : req0;

  lm32_logic_op u_logic_op (
    .op     (sel.op),
    .a      (sel.a),
    .b      (sel.b),
    .result (op_result)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= LM32_LOGIC_ARB_EMPTY;
      result_q     <= '0;
      id_q         <= 1'b0;
      last_grant_q <= 1'b1;
    end else begin
      unique case (state_q)
        LM32_LOGIC_ARB_EMPTY: begin
          if (fire) begin
            state_q      <= LM32_LOGIC_ARB_FULL;
            result_q     <= op_result;
            id_q         <= grant;
            last_grant_q <= grant;
          end
        end
        LM32_LOGIC_ARB_FULL: begin
          if (rsp_ready_i) begin
            if (fire) begin
              result_q     <= op_result;
              id_q         <= grant;
              last_grant_q <= grant;
            end else begin
              state_q <= LM32_LOGIC_ARB_EMPTY;
            end
          end
        end
        default: state_q <= LM32_LOGIC_ARB_EMPTY;
      endcase
    end
  end

  assign rsp_valid_o  = (state_q == LM32_LOGIC_ARB_FULL);
  assign busy_o       = rsp_valid_o;
  assign rsp_result_o = result_q;
  assign rsp_id_o     = id_q;

endmodule

// File: tb/tb_lm32_logic_arbiter.sv
// Directed bench for lm32_logic_arbiter: round-robin and fixed-priority instances.
// Inputs driven and outputs sampled on the falling edge.
module tb_lm32_logic_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        v0, v1, rrdy;
  logic [3:0]  op0, op1;
  logic [31:0] a0, b0, a1, b1;

  logic        r_rdy0, r_rdy1, r_val, r_id, r_busy;
  logic [31:0] r_res;
  logic        f_rdy0, f_rdy1, f_val, f_id, f_busy;
  logic [31:0] f_res;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  lm32_logic_arbiter #(.FIXED_PRIORITY(0)) dut_rr (
    .clk_i(clk), .rst_i(rst),
    .req0_valid_i(v0), .req0_ready_o(r_rdy0),
    .req0_op_i(op0), .req0_a_i(a0), .req0_b_i(b0),
    .req1_valid_i(v1), .req1_ready_o(r_rdy1),
    .req1_op_i(op1), .req1_a_i(a1), .req1_b_i(b1),
    .rsp_valid_o(r_val), .rsp_ready_i(rrdy),
    .rsp_result_o(r_res), .rsp_id_o(r_id), .busy_o(r_busy)
  );

  lm32_logic_arbiter #(.FIXED_PRIORITY(1)) dut_fp (
    .clk_i(clk), .rst_i(rst),
    .req0_valid_i(v0), .req0_ready_o(f_rdy0),
    .req0_op_i(op0), .req0_a_i(a0), .req0_b_i(b0),
    .req1_valid_i(v1), .req1_ready_o(f_rdy1),
    .req1_op_i(op1), .req1_a_i(a1), .req1_b_i(b1),
    .rsp_valid_o(f_val), .rsp_ready_i(rrdy),
    .rsp_result_o(f_res), .rsp_id_o(f_id), .busy_o(f_busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk_rsp(input string tag, input logic [31:0] res,
                         input logic id);
    chk({tag, "_valid"}, {31'd0, r_val}, 32'd1);
    chk({tag, "_busy"}, {31'd0, r_busy}, 32'd1);
    chk({tag, "_res"}, r_res, res);
    chk({tag, "_id"}, {31'd0, r_id}, {31'd0, id});
  endtask

  initial begin
    rst = 1'b1; v0 = 1'b1; v1 = 1'b1; rrdy = 1'b0;
    op0 = 4'b0110; a0 = 32'hAAAA_AAAA; b0 = 32'hFFFF_FFFF;
    op1 = 4'b1110; a1 = 32'h0000_000F; b1 = 32'h0000_00F0;

    // Reset state with both ports requesting.
    @(negedge clk);
    chk("rst_valid", {31'd0, r_val}, 32'd0);
    chk("rst_res", r_res, 32'd0);
    chk("rst_id", {31'd0, r_id}, 32'd0);
    chk("rst_rdy0", {31'd0, r_rdy0}, 32'd0);
    chk("rst_rdy1", {31'd0, r_rdy1}, 32'd0);

    // Round-robin tie: port 0 first, then alternate.
    rst = 1'b0; rrdy = 1'b1;
    #1;
    chk("tie0_rdy0", {31'd0, r_rdy0}, 32'd1);
    chk("tie0_rdy1", {31'd0, r_rdy1}, 32'd0);
    tick();
    chk_rsp("tie1", 32'h5555_5555, 1'b0);
    chk("tie1_rdy1", {31'd0, r_rdy1}, 32'd1);
    chk("tie1_rdy0", {31'd0, r_rdy0}, 32'd0);
    tick();
    chk_rsp("tie2", 32'h0000_00FF, 1'b1);
    chk("tie2_rdy0", {31'd0, r_rdy0}, 32'd1);
    tick();
    chk_rsp("tie3", 32'h5555_5555, 1'b0);
    tick();
    chk_rsp("tie4", 32'h0000_00FF, 1'b1);

    // Backpressure: buffer full, consumer stalls, port 1 waits.
    v0 = 1'b0; rrdy = 1'b0;
    op1 = 4'b0110; a1 = 32'h1234_5678; b1 = 32'hFFFF_0000;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("bp_rdy1", {31'd0, r_rdy1}, 32'd0);
      tick();
      chk_rsp("bp_hold", 32'h0000_00FF, 1'b1);
    end
    rrdy = 1'b1;
    #1;
    chk("bp_pop_rdy1", {31'd0, r_rdy1}, 32'd1);
    tick();
    chk_rsp("bp_new", 32'hEDCB_5678, 1'b1);

    // Drain to EMPTY.
    v1 = 1'b0;
    tick();
    chk("drain_valid", {31'd0, r_val}, 32'd0);
    chk("drain_busy", {31'd0, r_busy}, 32'd0);

    // Single AND on port 0.
    v0 = 1'b1; op0 = 4'b1000; a0 = 32'hF0F0_1234; b0 = 32'hFF00_00FF;
    #1;
    chk("and_rdy0", {31'd0, r_rdy0}, 32'd1);
    chk("and_rdy1", {31'd0, r_rdy1}, 32'd0);
    tick();
    chk_rsp("and", 32'hF000_0034, 1'b0);

    // Edge ops, back to back on port 0.
    op0 = 4'b0001; a0 = 32'd0; b0 = 32'd0;
    tick();
    chk_rsp("nor0", 32'hFFFF_FFFF, 1'b0);
    op0 = 4'b0000; a0 = 32'h1234_5678; b0 = 32'h5678_9ABC;
    tick();
    chk_rsp("op0000", 32'h0000_0000, 1'b0);
    op0 = 4'b1111; a0 = 32'h1234_5678; b0 = 32'h9ABC_DEF0;
    tick();
    chk_rsp("op1111", 32'hFFFF_FFFF, 1'b0);

    // Reset while FULL and stalled.
    rrdy = 1'b0; v1 = 1'b1;
    tick();
    rst = 1'b1;
    #1;
    chk("mrst_valid", {31'd0, r_val}, 32'd0);
    chk("mrst_res", r_res, 32'd0);
    chk("mrst_rdy0", {31'd0, r_rdy0}, 32'd0);
    chk("mrst_rdy1", {31'd0, r_rdy1}, 32'd0);
    chk("mrst_f_valid", {31'd0, f_val}, 32'd0);
    tick();
    op0 = 4'b0110; a0 = 32'hAAAA_AAAA; b0 = 32'hFFFF_FFFF;
    op1 = 4'b1110; a1 = 32'h0000_000F; b1 = 32'h0000_00F0;
    rst = 1'b0; rrdy = 1'b1;
    #1;
    chk("mrst_tie_rdy0", {31'd0, r_rdy0}, 32'd1);
    chk("mrst_tie_rdy1", {31'd0, r_rdy1}, 32'd0);

    // Fixed priority: port 0 wins every tie.
    for (int i = 0; i < 4; i++) begin
      chk("fp_rdy0", {31'd0, f_rdy0}, 32'd1);
      chk("fp_rdy1", {31'd0, f_rdy1}, 32'd0);
      tick();
      chk("fp_valid", {31'd0, f_val}, 32'd1);
      chk("fp_res", f_res, 32'h5555_5555);
      chk("fp_id", {31'd0, f_id}, 32'd0);
    end
    v0 = 1'b0;
    #1;
    chk("fp_p1_rdy1", {31'd0, f_rdy1}, 32'd1);
    tick();
    chk("fp_p1_res", f_res, 32'h0000_00FF);
    chk("fp_p1_id", {31'd0, f_id}, 32'd1);

    v1 = 1'b0;
    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/lm32_logic_arbiter.md
# lm32_logic_arbiter

Shares one `lm32_logic_op` bitwise unit between two requesters: port 0 for the pipeline X-stage and port 1 for a co-processor/debug extension. Requests use a valid/ready handshake, and arbitration is round-robin or fixed priority. Each result is registered in a single-entry output buffer and is returned with the ID of the requester that issued it. Throughput is one operation per cycle; latency is one cycle.

## Interface
Parameters:
- `FIXED_PRIORITY`, default 0: 0 selects round-robin; 1 means port 0 always wins.

Ports:
- `clk_i`  in  1  clock; all state updates on the rising edge.
- `rst_i`  in  1  reset, asynchronous, active-high.
- `req0_valid_i`  in  1  port 0 request valid.
- `req0_ready_o`  out  1  port 0 request accepted this cycle.
- `req0_op_i`  in  `LM32_LOGIC_OP_RNG` (4)  truth-table op code; result bit = op[{b,a}].
- `req0_a_i`, `req0_b_i`  in  `LM32_WORD_RNG` (32)  operands 0 and 1.
- `req1_valid_i`, `req1_ready_o`, `req1_op_i`, `req1_a_i`, `req1_b_i`: same as port 0, for port 1.
- `rsp_valid_o`  out  1  result buffer full.
- `rsp_ready_i`  in  1  consumer takes the result.
- `rsp_result_o`  out  32  registered logic result.
- `rsp_id_o`  out  1  ID of the port that issued the result.
- `busy_o`  out  1  equals `rsp_valid_o`; kept for the stall logic.

## Operation
FSM with two states:
- **EMPTY**: the result buffer is empty.
- **FULL**: the result buffer is valid.

Arbitration:
- `free = (state==EMPTY) | rsp_ready_i`.
- Grant when only one port is valid: that port.
- Grant when both are valid, round-robin: the port ≠ `last_grant_q`.
- Grant when both are valid, `FIXED_PRIORITY=1`: port 0.
- `reqN_ready_o = grant==N & reqN_valid_i & free`. At most one ready is high per cycle.
- Ready depends combinationally on valid. Requesters must not make valid depend on ready.

Accept (`fire = any ready`):
- The granted op/a/b are muxed into the single `lm32_logic_op` instance.
- The result goes to `rsp_result_o`, the port ID to `rsp_id_o`, and `last_grant_q` is updated to the granted port.
- The next state is FULL.

FSM transitions:
- EMPTY, `fire`: go to FULL.
- FULL, `rsp_ready_i & fire`: stay FULL and load the new result (back-to-back).
- FULL, `rsp_ready_i & !fire`: go to EMPTY.
- FULL, `!rsp_ready_i`: hold everything, and both readies are 0 (backpressure).

Requester contract:
- Op and operands must be held stable while valid is high and ready is low.
- A requester must not drop valid before acceptance.

Reset values:
- state = EMPTY.
- `rsp_valid_o` = 0, `rsp_result_o` = 0, `rsp_id_o` = 0.
- `last_grant_q` = 1, so port 0 wins the first tie.
- Both readies = 0 while `rst_i` is high.
- A reset mid-operation discards the held result. No response for it is ever produced.

## Timing
- Latency is 1: a request accepted at edge N has its result visible after edge N.
- Sustained throughput is 1 op/cycle while `rsp_ready_i` stays high.
- Under a continuous tie in round-robin mode, grants alternate 0,1,0,1 with no bubbles.
- A simultaneous response pop and new request is accepted in the same cycle. No dead cycle.
- `rsp_*` outputs are register-driven, with no combinational path from inputs.
- `reqN_ready_o` has a combinational path from `reqN_valid_i` and `rsp_ready_i`.

## Structure
- Op-code width and word width come from the existing `LM32_LOGIC_OP_RNG`, `LM32_WORD_RNG` and `LM32_WORD_WIDTH` in `lm32_include.v`.
- Add `LM32_LOGIC_ARB_EMPTY` and `LM32_LOGIC_ARB_FULL` state encodings (1 bit) to `lm32_include.v`.
- Add named op-code constants: AND 4'b1000, OR 4'b1110, XOR 4'b0110, NOR 4'b0001.
- Exactly one sub-module: an instance of the existing `lm32_logic_op`, fed by the 2:1 grant mux. The arbiter must not re-implement the truth-table evaluation.

## Test plan
- **Reset:** `rst_i` pulsed mid-FULL with `rsp_ready_i`=0 → `rsp_valid_o`=0, `rsp_result_o`=0 and both readies 0 during reset. After release, port 0 wins the first tie.
- **Single op, port 0:** op=4'b1000 (AND), a=0xF0F0_1234, b=0xFF00_00FF, `rsp_ready_i`=1 → `req0_ready_o`=1 in that cycle. Next cycle: `rsp_valid_o`=1, result 0xF000_0034, id 0.
- **Tie, round-robin:** both ports valid continuously, port 0 XOR (4'b0110) 0xAAAA_AAAA^0xFFFF_FFFF, port 1 OR (4'b1110) 0x0000_000F|0x0000_00F0 → results alternate: 0x5555_5555/id0, 0x0000_00FF/id1, and so on, one per cycle.
- **Backpressure:** `rsp_ready_i`=0 for 3 cycles with port 1 valid and the buffer FULL → `req1_ready_o`=0 and `rsp_*` stable. Raising `rsp_ready_i` pops the held result and accepts port 1 in the same cycle.
- **Fixed priority:** `FIXED_PRIORITY`=1 with both ports valid for 4 cycles → all 4 grants go to port 0 and port 1 stays not-ready. Port 1 is granted in the first cycle port 0 deasserts.
- **NOR edge:** op 4'b0001, a=b=0 → result 0xFFFF_FFFF. Op 4'b0000 → 0. Op 4'b1111 → 0xFFFF_FFFF regardless of operands.
